// File: rtl/msft_dv_debug_pkg.sv
// Shared definitions for the debug SPI/APB bridge memory target.
package msft_dv_debug_pkg;

  localparam int unsigned DBG_DATA_W  = 32;
  localparam int unsigned DBG_APB_DW  = 48;
  localparam int unsigned DBG_TAG_BIT = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DONE,
    ST_DRAIN
  } dbg_mem_state_e;

endpackage

// File: rtl/msft_dv_debug_apb32_mem.sv
// APB32 target converting each debug APB transfer into one word access on a
// req/gnt/rvalid memory port. Reports misalignment, memory error and timeout
// on psuberr32, and drains a response abandoned on timeout.
import msft_dv_debug_pkg::*;

module msft_dv_debug_apb32_mem #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel32,
  input  logic                  penable32,
  input  logic [31:0]           paddr32,
  input  logic                  pwrite32,
  input  logic [DBG_APB_DW-1:0] pwdata32,
  output logic [DBG_APB_DW-1:0] prdata32,
  output logic                  pready32,
  output logic                  psuberr32,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic [31:0]           mem_addr,
  output logic                  mem_we,
  output logic [DBG_DATA_W-1:0] mem_wdata,
  output logic                  mem_wtag,
  input  logic                  mem_rvalid,
  input  logic [DBG_DATA_W-1:0] mem_rdata,
  input  logic                  mem_rtag,
  input  logic                  mem_err
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam int unsigned PAD_W   = DBG_APB_DW - DBG_DATA_W - 1;

  dbg_mem_state_e state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  drain_pend_q, drain_pend_d;
  logic                  tmo;

  logic                  pready_d, psuberr_d, req_d, we_d, wtag_d;
  logic [DBG_APB_DW-1:0] prdata_d;
  logic [31:0]           addr_d;
  logic [DBG_DATA_W-1:0] wdata_d;

  // Upper pwdata32 bits carry nothing for this target.
  logic unused_pwdata_hi;
  assign unused_pwdata_hi = ^pwdata32[DBG_APB_DW-1:DBG_TAG_BIT+1];

  // Next-state, counter and registered-output values for every state.
  // prdata32 doubles as the read capture register: it is loaded only on a
  // successful read response and is zero in every other cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    drain_pend_d = drain_pend_q;
    pready_d     = 1'b0;
    psuberr_d    = 1'b0;
    prdata_d     = '0;
    req_d        = mem_req;
    addr_d       = mem_addr;
    we_d         = mem_we;
    wdata_d      = mem_wdata;
    wtag_d       = mem_wtag;
    // >= so a gnt that beats the timeout still times out on the next RESP cycle
    tmo          = (cnt_q >= TMO_LAST);

    unique case (state_q)
      ST_IDLE: begin
        if (psel32 && penable32) begin
          if (paddr32[1:0] != 2'b00) begin
            state_d   = ST_DONE;
            pready_d  = 1'b1;
            psuberr_d = 1'b1;
          end else begin
            state_d = ST_REQ;
            req_d   = 1'b1;
            addr_d  = {paddr32[31:2], 2'b00};
            we_d    = pwrite32;
            wdata_d = pwdata32[DBG_DATA_W-1:0];
            wtag_d  = pwdata32[DBG_TAG_BIT];
            cnt_d   = '0;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_gnt) begin
          state_d = ST_RESP;
          req_d   = 1'b0;
        end else if (tmo) begin
          state_d   = ST_DONE;
          req_d     = 1'b0;
          pready_d  = 1'b1;
          psuberr_d = 1'b1;
        end
      end
      ST_RESP: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_rvalid) begin
          state_d   = ST_DONE;
          pready_d  = 1'b1;
          psuberr_d = mem_err;
          if (!mem_we && !mem_err)
            prdata_d = {{PAD_W{1'b0}}, mem_rtag, mem_rdata};
        end else if (tmo) begin
          state_d      = ST_DONE;
          pready_d     = 1'b1;
          psuberr_d    = 1'b1;
          drain_pend_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = drain_pend_q ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        if (mem_rvalid) begin
          drain_pend_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and all output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      drain_pend_q <= 1'b0;
      pready32     <= 1'b0;
      psuberr32    <= 1'b0;
      prdata32     <= '0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      mem_we       <= 1'b0;
      mem_wdata    <= '0;
      mem_wtag     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      drain_pend_q <= drain_pend_d;
      pready32     <= pready_d;
      psuberr32    <= psuberr_d;
      prdata32     <= prdata_d;
      mem_req      <= req_d;
      mem_addr     <= addr_d;
      mem_we       <= we_d;
      mem_wdata    <= wdata_d;
      mem_wtag     <= wtag_d;
    end
  end

endmodule

// File: doc/msft_dv_debug_apb32_mem.md
# msft_dv_debug_apb32_mem

APB32 target that sits directly downstream of the debug SPI-to-APB16-to-APB32 bridge. It converts each 32-bit-address, 48-bit-data APB transfer into one word access on a req/gnt/rvalid memory port, so the SPI debugger can read and write system memory and tag bits. It also owns error reporting toward the bridge (`psuberr32`): misalignment, memory error and timeout. A transaction abandoned on timeout is drained safely.

## Interface
- `TIMEOUT_CYCLES`, 255: max cycles from entering REQ to `mem_rvalid` before the access is aborted; 8-bit counter, must be 1..255.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `psel32` in 1: APB select from bridge.
- `penable32` in 1: APB enable.
- `paddr32` in 32: byte address.
- `pwrite32` in 1: 1 = write.
- `pwdata32` in 48: [31:0] data, [32] tag, [47:33] ignored.
- `prdata32` out 48: {15'b0, tag, data}; valid only while `pready32`=1.
- `pready32` out 1: one-cycle completion pulse.
- `psuberr32` out 1: error flag, qualified by `pready32`.
- `mem_req` out 1: request, held until `mem_gnt`.
- `mem_gnt` in 1: request accepted this cycle.
- `mem_addr` out 32: {`paddr32`[31:2], 2'b00}.
- `mem_we` out 1: write enable.
- `mem_wdata` out 32: write data.
- `mem_wtag` out 1: write tag.
- `mem_rvalid` in 1: response valid, exactly one per granted request.
- `mem_rdata` in 32: read data.
- `mem_rtag` in 1: read tag.
- `mem_err` in 1: response error, qualified by `mem_rvalid`.

## Operation
- States: IDLE, REQ, RESP, DONE, DRAIN.
- IDLE:
  - `psel32 & penable32` and `paddr32[1:0]!=0` → DONE with error set; no memory access.
  - Otherwise, `psel32 & penable32` → REQ. Latch addr, we, wdata, tag; clear counter.
- REQ: `mem_req`=1 with latched fields. `mem_gnt` → RESP.
- RESP: wait for `mem_rvalid`.
  - On `mem_rvalid`, capture rdata/rtag (reads only; writes leave the read register unchanged).
  - error ← `mem_err`; → DONE.
- Timeout:
  - Counter increments every cycle in REQ and RESP.
  - Reaching `TIMEOUT_CYCLES` in REQ: drop `mem_req`, → DONE with error.
  - Reaching `TIMEOUT_CYCLES` in RESP: → DONE with error, and set `drain_pend`.
  - `mem_gnt` and timeout in the same REQ cycle: gnt wins; counter keeps running in RESP.
  - `mem_rvalid` and timeout in the same cycle: rvalid wins, no error.
- DONE: `pready32`=1 for exactly one cycle, `psuberr32`=error.
  - `prdata32` = captured read data on a successful read, else 48'h0.
  - Next state: DRAIN if `drain_pend`, else IDLE.
- DRAIN: ignore APB. First `mem_rvalid` is discarded, then clear `drain_pend` and go to IDLE. DRAIN has no timeout.
- The upstream bridge holds `psel32`/`penable32` until `pready32` and drops them on the edge after it, so IDLE never re-triggers on a finished transfer.
- Reset at any state:
  - State → IDLE, `drain_pend`=0, counter=0.
  - Outputs: `pready32`=0, `psuberr32`=0, `prdata32`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wtag`=0.
  - A memory response arriving after reset is ignored, because IDLE does not look at `mem_rvalid`.

## Timing
- All outputs are registered.
- Zero-wait memory (gnt in first REQ cycle, rvalid the following cycle):
  - `penable32` first sampled high at edge E0.
  - `mem_req` high in cycle E0+1; rvalid in cycle E0+2.
  - `pready32` high in cycle E0+3.
- Misaligned access: `pready32` with `psuberr32` in cycle E0+1.
- Each gnt cycle and each rvalid wait cycle adds one cycle of latency.
- `mem_req` stays high, with stable addr/we/data, from REQ entry until the gnt cycle inclusive.

## Structure
- Shared package `msft_dv_debug_pkg`:
  - State enum `dbg_mem_state_e`.
  - `DBG_DATA_W`=32, `DBG_APB_DW`=48, `DBG_TAG_BIT`=32.
- No sub-module. Counter, FSM and capture registers stay in one file.

## Test plan
- Aligned read of 0x2000_0010, memory returns 0xDEAD_BEEF with tag=1 → `prdata32`=48'h0001_DEAD_BEEF, `psuberr32`=0, `pready32` at E0+3.
- Write 0x1000_0004 with `pwdata32`=48'h0001_1234_5678, gnt delayed 3 cycles → `mem_req` held 4 cycles with addr/data/wtag stable, `pready32` at E0+6, no error.
- Access to 0x1000_0002 → no `mem_req`, `pready32` and `psuberr32` at E0+1, `prdata32`=0.
- Read with `mem_rvalid` & `mem_err` → `psuberr32`=1, `prdata32`=0.
- `TIMEOUT_CYCLES`=8, gnt given but rvalid withheld → `psuberr32` pulse.
  - A second APB read is then stalled until the late rvalid arrives; that rvalid is discarded.
  - The second read then completes with its own data.
- Assert `rst` while in RESP → all outputs 0 next cycle; a stray `mem_rvalid` produces no `pready32`; the next transfer completes normally.
